// File: rtl/pong_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pong_frame_scheduler                                       |
// | Description : Runs the per-frame game-logic tasks in vertical blanking.  |
// |               The tasks run in a fixed order with a start/done handshake.|
// |               A commit pulse is issued when all tasks finish, or an      |
// |               abort is issued if the deadline line arrives first.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module pong_frame_scheduler #(
    parameter int N_TASKS       = 4,
    parameter int H_TOTAL       = 800,
    parameter int V_ACTIVE      = 480,
    parameter int V_TOTAL       = 525,
    parameter int DEADLINE_LINE = 524,
    parameter int FRAME_DIV     = 1
) (
    input  logic               clk_pxl,
    input  logic               reset_n,
    input  logic [9:0]         sx,
    input  logic [9:0]         sy,
    input  logic               enable,
    input  logic [N_TASKS-1:0] task_done,
    input  logic               overrun_clr,
    output logic [N_TASKS-1:0] task_start,
    output logic               commit,
    output logic               abort,
    output logic               busy,
    output logic               overrun,
    output logic [15:0]        frame_cnt
);

    localparam int               IDX_W         = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
    localparam logic [IDX_W-1:0] c_last_idx    = IDX_W'(N_TASKS - 1);
    localparam logic [9:0]       c_h_total     = 10'(H_TOTAL);
    localparam logic [9:0]       c_v_total     = 10'(V_TOTAL);
    localparam logic [9:0]       c_v_active    = 10'(V_ACTIVE);
    localparam logic [9:0]       c_deadline    = 10'(DEADLINE_LINE);
    localparam logic [3:0]       c_div_last    = 4'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_div;

    logic             w_in_range;
    logic             w_trigger;
    logic             w_deadline;
    logic             w_launch;
    logic             w_running;
    logic             w_abort;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_cur_done;

    // Counter positions outside the frame never produce a trigger or deadline.
    assign w_in_range = (sx < c_h_total) && (sy < c_v_total);
    assign w_trigger  = w_in_range && (sx == 10'd0) && (sy == c_v_active);
    assign w_deadline = w_in_range && (sx == 10'd0) && (sy == c_deadline);
    assign w_launch   = w_trigger && (r_div == 4'd0) && enable;
    assign w_running  = (r_state == S_START) || (r_state == S_WAIT);
    assign w_abort    = w_running && w_deadline;
    assign w_idx_next = r_idx + 1'b1;
    assign w_cur_done = task_done[r_idx];

    // Frame divider: counts every trigger, busy or not, so the cadence stays fixed.
    always_ff @(posedge clk_pxl or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= 4'd0;
        end else if (w_trigger) begin
            r_div <= (r_div >= c_div_last) ? 4'd0 : r_div + 4'd1;
        end
    end

    // Sequencer: one task at a time, then commit; deadline abandons the chain.
    always_ff @(posedge clk_pxl or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            task_start <= '0;
            commit     <= 1'b0;
            abort      <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            task_start <= '0;
            commit     <= 1'b0;
            abort      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state    <= S_START;
                        r_idx      <= '0;
                        task_start <= N_TASKS'(1);
                        busy       <= 1'b1;
                    end
                end
                S_START: begin
                    // The start pulse is on the output now; done is not looked at yet.
                    if (w_abort) begin
                        abort   <= 1'b1;
                        busy    <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Deadline takes priority over a done arriving in the same cycle.
                    if (w_abort) begin
                        abort   <= 1'b1;
                        busy    <= 1'b0;
                        r_idx   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_cur_done) begin
                        if (r_idx == c_last_idx) begin
                            commit  <= 1'b1;
                            r_state <= S_COMMIT;
                        end else begin
                            r_idx      <= w_idx_next;
                            task_start <= N_TASKS'(1) << w_idx_next;
                            r_state    <= S_START;
                        end
                    end
                end
                S_COMMIT: begin
                    // Commit is already in flight; the deadline no longer matters here.
                    frame_cnt <= frame_cnt + 16'd1;
                    busy      <= 1'b0;
                    r_idx     <= '0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun flag: an abort sets it and beats a simultaneous clear.
    always_ff @(posedge clk_pxl or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (w_abort) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pong_frame_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pong_frame_scheduler                                    |
// | Description : Directed self-checking bench for pong_frame_scheduler.     |
// |               Timing counters are driven directly to the trigger and     |
// |               deadline positions instead of sweeping whole frames.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pong_frame_scheduler;

    logic clk_pxl = 1'b0;
    always #5 clk_pxl = ~clk_pxl;

    // Main instance, default parameters
    logic        reset_n;
    logic [9:0]  sx, sy;
    logic        enable;
    logic [3:0]  task_done;
    logic        overrun_clr;
    logic [3:0]  task_start;
    logic        commit, abort, busy, overrun;
    logic [15:0] frame_cnt;

    // Second instance, FRAME_DIV = 3, every task answers at once
    logic        reset_n3;
    logic [9:0]  sx3, sy3;
    logic        enable3;
    logic [3:0]  task_done3;
    logic        overrun_clr3;
    logic [3:0]  task_start3;
    logic        commit3, abort3, busy3, overrun3;
    logic [15:0] frame_cnt3;

    pong_frame_scheduler dut (
        .clk_pxl(clk_pxl), .reset_n(reset_n), .sx(sx), .sy(sy), .enable(enable),
        .task_done(task_done), .overrun_clr(overrun_clr), .task_start(task_start),
        .commit(commit), .abort(abort), .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    pong_frame_scheduler #(.FRAME_DIV(3)) dut3 (
        .clk_pxl(clk_pxl), .reset_n(reset_n3), .sx(sx3), .sy(sy3), .enable(enable3),
        .task_done(task_done3), .overrun_clr(overrun_clr3), .task_start(task_start3),
        .commit(commit3), .abort(abort3), .busy(busy3), .overrun(overrun3), .frame_cnt(frame_cnt3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Events recorded by run_frame, indexed in cycles after the trigger cycle
    int          st_cyc [8];
    logic [3:0]  st_val [8];
    int          n_st;
    int          commit_cyc;
    int          abort_cyc;
    int          busy_low_cyc;
    logic        ovr_at_abort;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_pxl);
        #1;
    endtask

    // Trigger one vblank, then model the tasks: each answers 3 cycles after its
    // start unless it is the silent one. base is OR-ed onto task_done throughout.
    task automatic run_frame(input int max_cyc, input int silent, input int dl_at,
                             input logic [3:0] base, input logic en);
        int pend_task;
        int pend_at;
        pend_task    = 0;
        pend_at      = -1;
        n_st         = 0;
        commit_cyc   = -1;
        abort_cyc    = -1;
        busy_low_cyc = -1;
        ovr_at_abort = 1'b0;
        task_done    = base;
        enable       = en;
        sx           = 10'd0;
        sy           = 10'd480;
        tick;
        enable = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            if (task_start != 4'd0) begin
                if (n_st < 8) begin
                    st_cyc[n_st] = c;
                    st_val[n_st] = task_start;
                end
                n_st++;
                for (int i = 0; i < 4; i++) begin
                    if (task_start[i] && i != silent) begin
                        pend_task = i;
                        pend_at   = c + 3;
                    end
                end
            end
            if (commit && commit_cyc < 0) commit_cyc = c;
            if (abort && abort_cyc < 0) begin
                abort_cyc    = c;
                ovr_at_abort = overrun;
            end
            if (!busy && busy_low_cyc < 0) busy_low_cyc = c;
            task_done = base;
            if (c == pend_at) task_done[pend_task] = 1'b1;
            if (c == dl_at) begin
                sx = 10'd0;
                sy = 10'd524;
            end else begin
                sx = 10'd1;
                sy = 10'd481;
            end
            tick;
        end
        task_done = 4'd0;
        sx        = 10'd1;
        sy        = 10'd481;
    endtask

    initial begin
        logic [5:0] launched;
        int         idle_starts;
        int         idle_busy;

        reset_n      = 1'b0;
        sx           = 10'd1;
        sy           = 10'd0;
        enable       = 1'b1;
        task_done    = 4'd0;
        overrun_clr  = 1'b0;
        reset_n3     = 1'b0;
        sx3          = 10'd1;
        sy3          = 10'd0;
        enable3      = 1'b1;
        task_done3   = 4'hF;
        overrun_clr3 = 1'b0;
        launched     = 6'd0;

        repeat (3) tick;
        reset_n = 1'b1;
        repeat (2) tick;

        // Reset state
        check_eq("rst_task_start", task_start, 0);
        check_eq("rst_commit", commit, 0);
        check_eq("rst_abort", abort, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);

        // 1: full sequence, done 3 cycles after each start
        run_frame(24, -1, -1, 4'd0, 1'b1);
        check_eq("t1_n_starts", n_st, 4);
        check_eq("t1_st0_cyc", st_cyc[0], 1);
        check_eq("t1_st0_val", st_val[0], 4'b0001);
        check_eq("t1_st1_cyc", st_cyc[1], 5);
        check_eq("t1_st1_val", st_val[1], 4'b0010);
        check_eq("t1_st2_cyc", st_cyc[2], 9);
        check_eq("t1_st2_val", st_val[2], 4'b0100);
        check_eq("t1_st3_cyc", st_cyc[3], 13);
        check_eq("t1_st3_val", st_val[3], 4'b1000);
        check_eq("t1_commit_cyc", commit_cyc, 17);
        check_eq("t1_busy_low_cyc", busy_low_cyc, 18);
        check_eq("t1_no_abort", abort_cyc, 32'hFFFF_FFFF);
        check_eq("t1_frame_cnt", frame_cnt, 1);

        // 2: task 2 never answers; deadline line reached in WAIT
        run_frame(24, 2, 20, 4'd0, 1'b1);
        check_eq("t2_n_starts", n_st, 3);
        check_eq("t2_abort_cyc", abort_cyc, 21);
        check_eq("t2_busy_low_cyc", busy_low_cyc, 21);
        check_eq("t2_no_commit", commit_cyc, 32'hFFFF_FFFF);
        check_eq("t2_overrun", overrun, 1);
        check_eq("t2_frame_cnt", frame_cnt, 1);
        overrun_clr = 1'b1;
        tick;
        overrun_clr = 1'b0;
        check_eq("t2_overrun_clr", overrun, 0);

        // 4: enable low at the trigger, high one cycle later
        run_frame(24, -1, -1, 4'd0, 1'b0);
        check_eq("t4_no_start", n_st, 0);
        check_eq("t4_no_commit", commit_cyc, 32'hFFFF_FFFF);
        check_eq("t4_frame_cnt_hold", frame_cnt, 1);
        run_frame(24, -1, -1, 4'd0, 1'b1);
        check_eq("t4_next_commit_cyc", commit_cyc, 17);
        check_eq("t4_next_frame_cnt", frame_cnt, 2);

        // 5a: done[3] held high throughout; only matters once task 3 is waited on
        run_frame(24, -1, -1, 4'b1000, 1'b1);
        check_eq("t5_n_starts", n_st, 4);
        check_eq("t5_st1_val", st_val[1], 4'b0010);
        check_eq("t5_st2_val", st_val[2], 4'b0100);
        check_eq("t5_st3_cyc", st_cyc[3], 13);
        check_eq("t5_st3_val", st_val[3], 4'b1000);
        check_eq("t5_commit_cyc", commit_cyc, 15);
        check_eq("t5_frame_cnt", frame_cnt, 3);

        // 5b: done[0] coincides with the deadline; clear held to show set wins
        overrun_clr = 1'b1;
        run_frame(12, -1, 4, 4'd0, 1'b1);
        overrun_clr = 1'b0;
        check_eq("t5b_n_starts", n_st, 1);
        check_eq("t5b_abort_cyc", abort_cyc, 5);
        check_eq("t5b_overrun_set_wins", ovr_at_abort, 1);
        check_eq("t5b_no_commit", commit_cyc, 32'hFFFF_FFFF);
        check_eq("t5b_frame_cnt", frame_cnt, 3);

        // 3: FRAME_DIV=3, six frames, launches only on frames 0 and 3
        reset_n3 = 1'b1;
        tick;
        for (int f = 0; f < 6; f++) begin
            sx3 = 10'd0;
            sy3 = 10'd480;
            tick;
            sx3 = 10'd1;
            sy3 = 10'd481;
            for (int c = 0; c < 12; c++) begin
                if (task_start3 != 4'd0) launched[f] = 1'b1;
                tick;
            end
        end
        check_eq("t3_launch_f0", launched[0], 1);
        check_eq("t3_launch_f1", launched[1], 0);
        check_eq("t3_launch_f2", launched[2], 0);
        check_eq("t3_launch_f3", launched[3], 1);
        check_eq("t3_launch_f4", launched[4], 0);
        check_eq("t3_launch_f5", launched[5], 0);
        check_eq("t3_frame_cnt", frame_cnt3, 2);

        // 6: asynchronous reset while waiting on task 1
        run_frame(6, -1, -1, 4'd0, 1'b1);
        check_eq("t6_busy_before", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_async_task_start", task_start, 0);
        check_eq("t6_async_commit", commit, 0);
        check_eq("t6_async_abort", abort, 0);
        check_eq("t6_async_busy", busy, 0);
        check_eq("t6_async_overrun", overrun, 0);
        check_eq("t6_async_frame_cnt", frame_cnt, 0);
        #1;
        reset_n = 1'b1;
        idle_starts = 0;
        idle_busy   = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (task_start != 4'd0) idle_starts++;
            if (busy) idle_busy++;
        end
        check_eq("t6_idle_starts", idle_starts, 0);
        check_eq("t6_idle_busy", idle_busy, 0);
        run_frame(24, -1, -1, 4'd0, 1'b1);
        check_eq("t6_rerun_n_starts", n_st, 4);
        check_eq("t6_rerun_commit_cyc", commit_cyc, 17);
        check_eq("t6_rerun_frame_cnt", frame_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
